delay_arbiter: RTL

DELAY_ARBITER -- requirements
Module: delay_arbiter

---
 rtl/delay_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/delay_arbiter.sv
// -----------------------------------------------------------------------------
// delay_arbiter
//
// Round-robin arbiter in front of one shared delay counter. When idle, the
// block grants one pending requester and latches that requester's delay. It
// then counts up from zero to that delay, pausing while hold is high, and
// pulses done back to the same requester. After the done pulse the block
// spends one cycle in FIRE, returns to IDLE, and then arbitrates again.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : synchronous, active-high reset; overrides every other input
//   req        : level request per requester, held until granted
//   dly        : per-requester delay, slice i = dly[i*CBITS +: CBITS];
//                sampled only on the granting edge
//   hold       : freezes the running count while high
//   gnt        : registered one-hot grant pulse, one cycle wide
//   done       : registered one-hot completion pulse to the current grantee
//   busy       : high whenever the FSM is outside IDLE
//   active_id  : index of the current or most recent grantee
//   state_dbg  : current FSM state (0 = IDLE, 1 = COUNT, 2 = FIRE)
//
// Handshake: req is a level that the requester holds until it sees its gnt
// bit. The requester drops req in the cycle in which gnt is high, or keeps it
// up to ask again. gnt and done are single-cycle pulses that are never
// back-pressured. Requests seen outside IDLE are not stored; the requester
// must still be asserting req when the block next returns to IDLE.
// -----------------------------------------------------------------------------
module delay_arbiter #(
    parameter int NREQ  = 4,
    parameter int CBITS = 10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NREQ-1:0]                           req,
    input  logic [NREQ*CBITS-1:0]                     dly,
    input  logic                                      hold,
    output logic [NREQ-1:0]                           gnt,
    output logic [NREQ-1:0]                           done,
    output logic                                      busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] active_id,
    output logic [1:0]                                state_dbg
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t           state;
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] dly_q;

    // Index of the last winner. It is kept apart from active_id because reset
    // must give requester 0 top priority (so the pointer resets to NREQ-1),
    // while active_id resets to 0.
    logic [IDW-1:0]   rr_last;

    // Arbitration result for the current cycle; used only in IDLE.
    logic             win_valid;
    logic [IDW-1:0]   win_id;
    logic [CBITS-1:0] win_dly;

    // Build a one-hot vector from an index.
    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (id == IDW'(i));
        end
        return oh;
    endfunction

    // Round-robin search starting just above the last winner and wrapping.
    // Pass 1 scans the indices above rr_last in ascending order. If nothing
    // is found there, pass 2 takes the lowest set bit overall. That bit can
    // only be at or below rr_last, which completes the wrap-around.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_dly   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!win_valid && req[j] && (IDW'(j) > rr_last)) begin
                win_valid = 1'b1;
                win_id    = IDW'(j);
                win_dly   = dly[j*CBITS +: CBITS];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!win_valid && req[j]) begin
                win_valid = 1'b1;
                win_id    = IDW'(j);
                win_dly   = dly[j*CBITS +: CBITS];
            end
        end
    end

    // Main FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dly_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            active_id <= '0;
            rr_last   <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    gnt  <= '0;
                    done <= '0;
                    if (win_valid) begin
                        dly_q     <= win_dly;
                        cnt       <= '0;
                        gnt       <= onehot(win_id);
                        active_id <= win_id;
                        rr_last   <= win_id;
                        busy      <= 1'b1;
                        state     <= COUNT;
                    end
                end

                COUNT: begin
                    gnt <= '0;
                    // While hold is high, both the count and the compare are
                    // frozen. When the compare hits, the counter stops before
                    // it can wrap, because dly_q never exceeds the counter's
                    // range.
                    if (!hold) begin
                        if (cnt == dly_q) begin
                            done  <= onehot(active_id);
                            state <= FIRE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                FIRE: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

    // Output sanity: one-hot pulses, and gnt and done never high together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt));
            assert ($onehot0(done));
            assert ((gnt & done) == '0);
        end
    end

endmodule
